// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for a classic 5-stage in-order pipeline.
// Tracks the register usage of the instructions in EX, MEM and WB, selects
// the EX operand bypass sources, and detects load-use and redirect hazards
// at the ID/EX boundary.
module fwd_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        ex_redirect,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        stall_if_id,
  output logic        flush_id_ex,
  output logic        flush_if_id,
  output logic [15:0] stall_count
);

  // Register-usage summary of one in-flight instruction.
  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } slot_t;

  localparam slot_t SlotBubble = '0;

  typedef enum logic [1:0] {
    FwdRegFile = 2'b00,
    FwdMem     = 2'b01,
    FwdWb      = 2'b10
  } fwd_sel_e;

  localparam logic [15:0] StallCntMax = 16'hFFFF;

  slot_t       ex_q, ex_d;
  slot_t       mem_q, mem_d;
  slot_t       wb_q, wb_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        load_use;

  // A slot may feed the bypass network only if it will really write a
  // non-zero architectural register.
  function automatic logic is_producer(slot_t s);
    return s.valid & s.reg_write & (s.rd != 5'd0);
  endfunction

  // Youngest matching producer wins: MEM is checked before WB.
  function automatic fwd_sel_e fwd_select(logic ex_valid, logic use_src, logic [4:0] src,
                                          slot_t mem, slot_t wb);
    fwd_sel_e sel;
    sel = FwdRegFile;
    if (ex_valid && use_src) begin
      if (is_producer(mem) && (mem.rd == src)) begin
        sel = FwdMem;
      end else if (is_producer(wb) && (wb.rd == src)) begin
        sel = FwdWb;
      end
    end
    return sel;
  endfunction

  // Operand bypass selects, purely from the tracking slots.
  always_comb begin
    fwd_a_sel = fwd_select(ex_q.valid, ex_q.use_rs1, ex_q.rs1, mem_q, wb_q);
    fwd_b_sel = fwd_select(ex_q.valid, ex_q.use_rs2, ex_q.rs2, mem_q, wb_q);
  end

  // Load-use detection and stall/flush decode; redirect overrides the stall.
  always_comb begin
    load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & id_valid &
               ((id_use_rs1 & (id_rs1 == ex_q.rd)) | (id_use_rs2 & (id_rs2 == ex_q.rd)));
    stall_if_id = load_use & ~ex_redirect;
    flush_id_ex = load_use | ex_redirect;
    flush_if_id = ex_redirect;
  end

  // Slot advance: ID enters EX unless a bubble is being inserted.
  always_comb begin
    wb_d  = mem_q;
    mem_d = ex_q;
    ex_d  = SlotBubble;
    if (!flush_id_ex) begin
      ex_d.valid     = id_valid;
      ex_d.rs1       = id_rs1;
      ex_d.rs2       = id_rs2;
      ex_d.use_rs1   = id_use_rs1;
      ex_d.use_rs2   = id_use_rs2;
      ex_d.rd        = id_rd;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
    end
  end

  // Saturating count of real load-use stall cycles (redirected ones excluded).
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_if_id && (stall_cnt_q != StallCntMax)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Tracking slots and stall counter, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= SlotBubble;
      mem_q       <= SlotBubble;
      wb_q        <= SlotBubble;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;

  // WB source fields are kept for visibility but nothing downstream reads them.
  logic unused_wb_fields;
  assign unused_wb_fields = ^{wb_q.rs1, wb_q.rs2, wb_q.use_rs1, wb_q.use_rs2, wb_q.mem_read};

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed scenarios followed by random traffic,
// all checked against an instruction-level model of the pipeline.
module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic        ex_redirect;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall_if_id, flush_id_ex, flush_if_id;
  logic [15:0] stall_count;

  int passed = 0;
  int total  = 0;

  fwd_hazard_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_reg_write(id_reg_write),
    .id_mem_read (id_mem_read),
    .ex_redirect (ex_redirect),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall_if_id (stall_if_id),
    .flush_id_ex (flush_id_ex),
    .flush_if_id (flush_if_id),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  // Model: an instruction record, and the list of instructions issued into
  // EX, youngest first (index 0 = EX, 1 = MEM, 2 = WB).
  typedef struct {
    bit v;
    int rs1;
    int rs2;
    bit u1;
    bit u2;
    int rd;
    bit rw;
    bit mr;
  } ins_t;

  ins_t bub = '{0, 0, 0, 0, 0, 0, 0, 0};
  ins_t pipe[$];
  ins_t cur;
  bit   cur_redir;
  int   cnt;

  function automatic ins_t mk(int rs1, int rs2, bit u1, bit u2, int rd, bit rw, bit mr);
    ins_t i;
    i = '{1, rs1, rs2, u1, u2, rd, rw, mr};
    return i;
  endfunction

  function automatic bit prod(ins_t s);
    return s.v && s.rw && (s.rd != 0);
  endfunction

  // Distance back to the youngest older writer of src equals the select code.
  function automatic int exp_sel(bit use_src, int src);
    if (!pipe[0].v || !use_src) return 0;
    for (int k = 1; k <= 2; k++) begin
      if (prod(pipe[k]) && (pipe[k].rd == src)) return k;
    end
    return 0;
  endfunction

  function automatic bit exp_haz();
    ins_t e;
    e = pipe[0];
    return e.v && e.mr && (e.rd != 0) && cur.v &&
           ((cur.u1 && (cur.rs1 == e.rd)) || (cur.u2 && (cur.rs2 == e.rd)));
  endfunction

  task automatic check(string tag, logic [31:0] obs, int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive(ins_t i, bit redir);
    cur          = i;
    cur_redir    = redir;
    id_valid     = i.v;
    id_rs1       = 5'(i.rs1);
    id_rs2       = 5'(i.rs2);
    id_use_rs1   = i.u1;
    id_use_rs2   = i.u2;
    id_rd        = 5'(i.rd);
    id_reg_write = i.rw;
    id_mem_read  = i.mr;
    ex_redirect  = redir;
  endtask

  // One clock cycle: compare outputs with the model, then advance the model.
  task automatic step(bit chk);
    bit haz;
    #1;
    haz = exp_haz();
    if (chk) begin
      check("fwd_a_sel", fwd_a_sel, exp_sel(pipe[0].u1, pipe[0].rs1));
      check("fwd_b_sel", fwd_b_sel, exp_sel(pipe[0].u2, pipe[0].rs2));
      check("stall_if_id", stall_if_id, int'(haz && !cur_redir));
      check("flush_id_ex", flush_id_ex, int'(haz || cur_redir));
      check("flush_if_id", flush_if_id, int'(cur_redir));
      check("stall_count", stall_count, cnt);
    end
    @(posedge clk);
    if (rst) begin
      pipe = {bub, bub, bub};
      cnt  = 0;
    end else begin
      if (haz && !cur_redir && (cnt < 65535)) cnt++;
      pipe.push_front((haz || cur_redir) ? bub : cur);
      void'(pipe.pop_back());
    end
    @(negedge clk);
  endtask

  task automatic nops(int n);
    for (int k = 0; k < n; k++) begin
      drive(bub, 0);
      step(1);
    end
  endtask

  initial begin
    pipe = {bub, bub, bub};
    cnt  = 0;
    rst  = 1'b1;
    drive(bub, 0);
    step(0);
    step(1);
    rst = 1'b0;

    // Outputs right after reset.
    #1;
    check("rst_fwd_a", fwd_a_sel, 0);
    check("rst_fwd_b", fwd_b_sel, 0);
    check("rst_stall", stall_if_id, 0);
    check("rst_flush_id_ex", flush_id_ex, 0);
    check("rst_flush_if_id", flush_if_id, 0);
    check("rst_count", stall_count, 0);
    nops(1);

    // add x5,x1,x2 ; sub x6,x5,x3
    drive(mk(1, 2, 1, 1, 5, 1, 0), 0); step(1);
    drive(mk(5, 3, 1, 1, 6, 1, 0), 0); step(1);
    drive(bub, 0); #1;
    check("mem_fwd_a", fwd_a_sel, 1);
    check("mem_fwd_b", fwd_b_sel, 0);
    check("mem_fwd_stall", stall_if_id, 0);
    nops(3);

    // add x5 ; nop ; or x7,x4,x5
    drive(mk(1, 2, 1, 1, 5, 1, 0), 0); step(1);
    drive(bub, 0); step(1);
    drive(mk(4, 5, 1, 1, 7, 1, 0), 0); step(1);
    drive(bub, 0); #1;
    check("wb_fwd_b", fwd_b_sel, 2);
    nops(3);

    // add x5 ; add x5 ; or x7,x4,x5 -> MEM beats WB
    drive(mk(1, 2, 1, 1, 5, 1, 0), 0); step(1);
    drive(mk(3, 2, 1, 1, 5, 1, 0), 0); step(1);
    drive(mk(4, 5, 1, 1, 7, 1, 0), 0); step(1);
    drive(bub, 0); #1;
    check("prio_fwd_b", fwd_b_sel, 1);
    nops(3);

    // lw x8 ; add x9,x8,x8 -> one stall, then WB forwarding on both operands
    drive(mk(2, 0, 1, 0, 8, 1, 1), 0); step(1);
    drive(mk(8, 8, 1, 1, 9, 1, 0), 0); #1;
    check("lu_stall", stall_if_id, 1);
    check("lu_flush_id_ex", flush_id_ex, 1);
    check("lu_flush_if_id", flush_if_id, 0);
    check("lu_count_before", stall_count, 0);
    step(1);
    #1;
    check("lu_stall_cleared", stall_if_id, 0);
    check("lu_count_after", stall_count, 1);
    step(1);
    drive(bub, 0); #1;
    check("lu_fwd_a", fwd_a_sel, 2);
    check("lu_fwd_b", fwd_b_sel, 2);
    nops(3);

    // lw x8 ; dependent add with a redirect in the same cycle
    drive(mk(2, 0, 1, 0, 8, 1, 1), 0); step(1);
    drive(mk(8, 1, 1, 1, 9, 1, 0), 1); #1;
    check("redir_flush_if_id", flush_if_id, 1);
    check("redir_flush_id_ex", flush_id_ex, 1);
    check("redir_stall", stall_if_id, 0);
    step(1);
    drive(bub, 0); #1;
    check("redir_count", stall_count, 1);
    nops(3);

    // x0 writers and loads followed by x0 readers
    drive(mk(1, 2, 1, 1, 0, 1, 0), 0); step(1);
    drive(mk(3, 0, 1, 0, 0, 1, 1), 0); step(1);
    drive(mk(0, 0, 1, 1, 4, 1, 0), 0); #1;
    check("x0_stall", stall_if_id, 0);
    step(1);
    drive(bub, 0); #1;
    check("x0_fwd_a", fwd_a_sel, 0);
    check("x0_fwd_b", fwd_b_sel, 0);
    nops(3);

    // Reset arriving during a stall cycle
    drive(mk(2, 0, 1, 0, 8, 1, 1), 0); step(1);
    drive(mk(1, 8, 1, 1, 9, 1, 0), 0); #1;
    check("rstmid_stall", stall_if_id, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    #1;
    check("rstmid_stall_after", stall_if_id, 0);
    check("rstmid_flush_after", flush_id_ex, 0);
    check("rstmid_fwd_a", fwd_a_sel, 0);
    check("rstmid_fwd_b", fwd_b_sel, 0);
    check("rstmid_count", stall_count, 0);
    nops(3);

    // Counting over repeated load-use pairs
    for (int k = 0; k < 40; k++) begin
      drive(mk(2, 0, 1, 0, 8, 1, 1), 0); step(1);
      drive(mk(8, 8, 1, 1, 9, 1, 0), 0); step(1);
    end
    nops(2);
    #1;
    check("count_40", stall_count, 40);

    // Reaching saturation naturally needs ~131k cycles (one stall per two),
    // so the counter is preloaded just below the top.
    force dut.stall_cnt_q = 16'hFFFC;
    cnt = 65532;
    #1;
    release dut.stall_cnt_q;
    for (int k = 0; k < 6; k++) begin
      drive(mk(2, 0, 1, 0, 8, 1, 1), 0); step(1);
      drive(mk(1, 8, 0, 1, 9, 1, 1), 0); step(1);
    end
    nops(1);
    #1;
    check("count_saturated", stall_count, 16'hFFFF);
    rst = 1'b1;
    step(1);
    rst = 1'b0;

    // Random traffic over a small register set to provoke frequent hazards.
    for (int n = 0; n < 3000; n++) begin
      ins_t r;
      r.v   = ($urandom_range(0, 9) != 0);
      r.rs1 = $urandom_range(0, 3);
      r.rs2 = $urandom_range(0, 3);
      r.u1  = 1'($urandom_range(0, 1));
      r.u2  = 1'($urandom_range(0, 1));
      r.rd  = $urandom_range(0, 3);
      r.rw  = ($urandom_range(0, 3) != 0);
      r.mr  = ($urandom_range(0, 2) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      drive(r, ($urandom_range(0, 9) == 0));
      step(1);
    end
    rst = 1'b0;
    nops(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows (clock and reset first):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  5 each  ID source register indices.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1 / rs2.
- id_rd  in  5  ID destination index.
- id_reg_write  in  1  ID instruction writes rd.
- id_mem_read  in  1  ID instruction is a load.
- ex_redirect  in  1  branch/jump taken in EX; squash younger instructions.
- fwd_a_sel, fwd_b_sel  out  2 each  EX operand A/B mux select: 00 = register file, 01 = MEM-stage ALU result, 10 = WB-stage result, 11 never driven.
- stall_if_id  out  1  hold PC and IF/ID register.
- flush_id_ex  out  1  insert bubble into ID/EX.
- flush_if_id  out  1  squash IF/ID.
- stall_count  out  16  saturating count of load-use stall cycles.

Function
REQ-002 The block SHALL keep three registered tracking slots (EX, MEM, WB), each holding: valid, rs1, rs2, use_rs1, use_rs2, rd, reg_write, mem_read.
REQ-003 Each rising edge not in reset: WB <= MEM; MEM <= EX; EX <= ID fields with valid = id_valid, or a bubble (all fields 0) when flush_id_ex = 1.
REQ-004 A slot SHALL be a forwarding producer only when valid = 1, reg_write = 1 and rd != 0.
REQ-005 fwd_a_sel SHALL be 01 when the MEM slot is a producer with rd == EX.rs1; otherwise 10 when the WB slot is a producer with rd == EX.rs1; otherwise 00.
REQ-006 MEM SHALL take priority over WB when both match the same register (youngest value wins).
REQ-007 fwd_b_sel SHALL follow REQ-005/006 using EX.rs2.
REQ-008 Both selects SHALL be 00 whenever the EX slot is invalid or the corresponding use bit is 0.
REQ-009 Both selects SHALL be combinational functions of the slot registers only, valid in the same cycle the EX slot is valid (zero added latency).
REQ-010 A load-use hazard SHALL be detected when: EX.valid, EX.mem_read, EX.rd != 0, id_valid, and ((id_use_rs1 and id_rs1 == EX.rd) or (id_use_rs2 and id_rs2 == EX.rd)).
REQ-011 On a load-use hazard with ex_redirect = 0, the block SHALL assert stall_if_id = 1, flush_id_ex = 1 and flush_if_id = 0, for exactly one cycle.
REQ-012 After that one-cycle load-use stall, the load has moved to MEM, so the hazard SHALL clear and the dependent instruction SHALL enter EX, where it takes the load data through the WB path (10) one cycle later.
REQ-013 On ex_redirect = 1, the block SHALL assert flush_if_id = 1, flush_id_ex = 1 and stall_if_id = 0, regardless of any hazard; redirect SHALL take priority over stall.
REQ-014 stall_count SHALL increment by 1 on each cycle in which the REQ-011 stall is asserted, saturating at 16'hFFFF with no wrap-around.
REQ-015 Cycles where a redirect suppresses a stall SHALL NOT be counted in stall_count.
REQ-016 Register index 0 SHALL never cause forwarding or stall, even if reg_write or mem_read is set.
REQ-017 A consecutive load followed by a dependent load SHALL stall exactly one cycle per dependent pair; back-to-back hazards SHALL be handled each independently.

Reset
REQ-018 While rst = 1 at a clock edge, all slots SHALL clear to invalid and zero, and stall_count SHALL clear to 0.
REQ-019 One cycle after reset, all outputs SHALL read 0: selects 00, stall and flush signals 0, stall_count 0.
REQ-020 Reset asserted mid-stall or mid-redirect SHALL discard the in-flight hazard; no stall SHALL be asserted in the first cycle after reset release.

Verification
REQ-021 add x5,x1,x2 then sub x6,x5,x3 issued back-to-back -> in sub's EX cycle, fwd_a_sel = 01, fwd_b_sel = 00, no stall.
REQ-022 add x5 / nop / or x7,x4,x5 -> in or's EX cycle, fwd_b_sel = 10; with add x5 in WB and add x5 in MEM simultaneously -> fwd_b_sel = 01.
REQ-023 lw x8 then add x9,x8,x8 -> stall_if_id = 1 and flush_id_ex = 1 for one cycle, stall_count 0 -> 1, then add in EX with fwd_a_sel = fwd_b_sel = 10.
REQ-024 lw x8 / dependent add with ex_redirect = 1 in the same cycle -> flush_if_id = 1, flush_id_ex = 1, stall_if_id = 0, stall_count unchanged.
REQ-025 Writes and loads to x0 followed by readers of x0 -> selects stay 00, no stall; 65 540 forced stalls -> stall_count holds at 0xFFFF.
REQ-026 rst = 1 asserted during a stall cycle -> the next cycle shows all outputs 0 and stall_count = 0.
